// File: rtl/ccff_prog_pkg.sv
// Shared types and sizing helpers for the ccff programming controller.
package ccff_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // How a chain of chain_len bits splits into word_w-bit bitstream words.
  typedef struct packed {
    logic [31:0] n_words;
    logic [31:0] last_bits;
  } word_plan_t;

  function automatic word_plan_t calc_word_plan(input int unsigned chain_len,
                                                input int unsigned word_w);
    word_plan_t p;
    p.n_words   = (chain_len + word_w - 1) / word_w;
    p.last_bits = ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    return p;
  endfunction

endpackage

// File: rtl/ccff_prog_ctrl_if.sv
// Bitstream word stream (valid/ready) feeding the ccff programming controller.
interface ccff_prog_ctrl_if #(
  parameter int WORD_W = 32
) ();

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ccff_word_buf.sv
// One-word prefetch buffer. Accepts a word only while empty and enabled;
// the consumer pops it when it moves the word into its shift register.
module ccff_word_buf #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_pop
);

  logic [WORD_W-1:0] r_data;
  logic              r_valid;

  assign o_ready = i_en && !r_valid;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // Fill on handshake, drain on pop; fill and pop never coincide because
  // ready requires the buffer to be empty and pop requires it to be full.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ccff_prog_ctrl.sv
// Serial loader for a configuration flip-flop chain: takes bitstream words,
// shifts them LSB-first into the chain with a gated programming clock.
// Optional readback of the old chain contents: define CCFF_READBACK_EN.
module ccff_prog_ctrl
  import ccff_prog_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  ccff_prog_ctrl_if.slave   s_if,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam word_plan_t  PLAN    = calc_word_plan(CHAIN_LEN, WORD_W);
  localparam int unsigned N_WORDS = PLAN.n_words;
  localparam int          BC_W    = $clog2(CHAIN_LEN + 1);
  localparam int          WC_W    = $clog2(N_WORDS + 1);
  localparam int          WB_W    = $clog2(WORD_W + 1);
  localparam logic [WB_W-1:0] LAST_BITS = WB_W'(PLAN.last_bits);

  state_t            r_state, w_state_next;
  logic [WORD_W-1:0] r_shift;
  logic [WB_W-1:0]   r_wbits;     // bits still to shift from the current word
  logic [BC_W-1:0]   r_bit_cnt;   // bits shifted into the chain so far
  logic [WC_W-1:0]   r_word_cnt;  // words accepted from the stream
  logic              r_head;

  logic              w_buf_ready, w_buf_valid, w_pop, w_accept;
  logic [WORD_W-1:0] w_buf_data;
  logic              w_word_last, w_chain_last, w_accept_en;
  logic [WB_W-1:0]   w_load_bits;

  assign w_accept_en  = (r_state != ST_IDLE) && (r_word_cnt < WC_W'(N_WORDS));
  assign w_accept     = s_if.s_valid && w_buf_ready;
  assign s_if.s_ready = w_buf_ready;
  assign w_word_last  = (r_wbits == WB_W'(1));
  assign w_chain_last = (r_bit_cnt == BC_W'(CHAIN_LEN - 1));
  // The buffered word is always the most recently accepted one, so it is the
  // final word exactly when the accepted count has reached the word total.
  assign w_load_bits  = (r_word_cnt == WC_W'(N_WORDS)) ? LAST_BITS : WB_W'(WORD_W);
  // Move the buffered word into the shift register when idle-fetching, or
  // seamlessly on the cycle the current word runs out.
  assign w_pop = w_buf_valid &&
                 ((r_state == ST_FETCH) ||
                  ((r_state == ST_SHIFT) && w_word_last && !w_chain_last));

  ccff_word_buf #(.WORD_W(WORD_W)) u_word_buf (
    .clk     (prog_clk),
    .srst    (prog_reset),
    .i_en    (w_accept_en),
    .i_data  (s_if.s_data),
    .i_valid (s_if.s_valid),
    .o_ready (w_buf_ready),
    .o_data  (w_buf_data),
    .o_valid (w_buf_valid),
    .i_pop   (w_pop)
  );

  // State register
  always_ff @(posedge prog_clk) begin
    if (prog_reset) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_FETCH;
      ST_FETCH: if (w_buf_valid) w_state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_chain_last)                    w_state_next = ST_DONE;
        else if (w_word_last && !w_buf_valid) w_state_next = ST_FETCH;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; the head keeps its last shifted value while the gate is off
  always_comb begin
    busy        = (r_state != ST_IDLE);
    ccff_clk_en = (r_state == ST_SHIFT);
    done        = (r_state == ST_DONE);
    ccff_head   = ccff_clk_en ? r_shift[0] : r_head;
  end

  // Shift datapath and bit/word counters
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_shift    <= '0;
      r_wbits    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_head     <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_word_cnt <= r_word_cnt + WC_W'(1);
      end
      if (r_state == ST_SHIFT) begin
        r_head    <= r_shift[0];
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
      if (w_pop) begin
        r_shift <= w_buf_data;
        r_wbits <= w_load_bits;
      end else if (r_state == ST_SHIFT) begin
        r_shift <= {1'b0, r_shift[WORD_W-1:1]};
        r_wbits <= r_wbits - WB_W'(1);
      end
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] r_rb_acc, r_rb_data, w_rb_next;
  logic [WB_W-1:0]   r_rb_cnt;
  logic              r_rb_valid;

  assign w_rb_next = r_rb_acc | (WORD_W'(ccff_tail) << r_rb_cnt);
  assign rb_data   = r_rb_data;
  assign rb_valid  = r_rb_valid;

  // Collect the pre-edge tail bit each shift; publish on a full word or the final bit
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_rb_acc   <= '0;
      r_rb_cnt   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (ccff_clk_en) begin
        if ((r_rb_cnt == WB_W'(WORD_W - 1)) || w_chain_last) begin
          r_rb_data  <= w_rb_next;
          r_rb_valid <= 1'b1;
          r_rb_acc   <= '0;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_acc <= w_rb_next;
          r_rb_cnt <= r_rb_cnt + WB_W'(1);
        end
      end
    end
  end
`else
  logic w_tail_unused;
  assign w_tail_unused = ccff_tail;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// Bench for ccff_prog_ctrl: an 8-bit and a 40-bit chain instance, each with a
// behavioural chain model on the tail; loads are checked against the words.
module tb_ccff_prog_ctrl;

  localparam int W   = 32;
  localparam int LOG = 4096;

  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic [1:0]  start_v = '0;
  logic [1:0]  drv_valid = '0;
  logic [W-1:0] drv_data [2];
  logic [1:0]  rdy_v, head_v, en_v, tail_v, busy_v, done_v, rb_valid_v;
  logic [W-1:0] rb_data_v [2];

  always #5 prog_clk = ~prog_clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ccff_prog_ctrl_if #(.WORD_W(W)) u_if ();
    assign u_if.s_data  = drv_data[gi];
    assign u_if.s_valid = drv_valid[gi];
    assign rdy_v[gi]    = u_if.s_ready;
    ccff_prog_ctrl #(.CHAIN_LEN(gi == 0 ? 8 : 40), .WORD_W(W)) u_dut (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .start       (start_v[gi]),
      .s_if        (u_if),
      .ccff_head   (head_v[gi]),
      .ccff_clk_en (en_v[gi]),
      .ccff_tail   (tail_v[gi]),
      .busy        (busy_v[gi]),
      .done        (done_v[gi]),
      .rb_data     (rb_data_v[gi]),
      .rb_valid    (rb_valid_v[gi])
    );
  end

  // Chain models: each gated edge moves the head in and every bit one step tailward
  logic [39:0] chain [2] = '{40'h3C, 40'h5A_C3F0_9E17};
  always @(posedge prog_clk) begin
    if (en_v[0]) chain[0] <= {32'd0, head_v[0], chain[0][7:1]};
    if (en_v[1]) chain[1] <= {head_v[1], chain[1][39:1]};
  end
  assign tail_v = {chain[1][0], chain[0][0]};

  // Observation logs filled mid-cycle
  int cyc = 0;
  logic prev_rst = 1'b1;
  int en_cnt [2], done_cnt [2], done_cyc [2], acc_cnt [2], rb_cnt [2];
  int hold_bad [2], idle_rdy_bad [2], rb_nz [2];
  logic prev_head [2];
  bit head_log [2][LOG];
  int en_cyc_log [2][LOG];
  logic [W-1:0] rb_log [2][256];

  always @(negedge prog_clk) begin
    cyc <= cyc + 1;
    prev_rst <= prog_reset;
    for (int k = 0; k < 2; k++) begin
      if (en_v[k]) begin
        if (en_cnt[k] < LOG) begin
          head_log[k][en_cnt[k]]   <= head_v[k];
          en_cyc_log[k][en_cnt[k]] <= cyc;
        end
        en_cnt[k] <= en_cnt[k] + 1;
      end else if (!prog_reset && !prev_rst && head_v[k] !== prev_head[k]) begin
        hold_bad[k] <= hold_bad[k] + 1;
      end
      prev_head[k] <= head_v[k];
      if (done_v[k]) begin
        done_cnt[k] <= done_cnt[k] + 1;
        done_cyc[k] <= cyc;
      end
      if (drv_valid[k] && rdy_v[k]) acc_cnt[k] <= acc_cnt[k] + 1;
      if (!busy_v[k] && rdy_v[k]) idle_rdy_bad[k] <= idle_rdy_bad[k] + 1;
      if (rb_valid_v[k]) begin
        if (rb_cnt[k] < 256) rb_log[k][rb_cnt[k]] <= rb_data_v[k];
        rb_cnt[k] <= rb_cnt[k] + 1;
      end
      if (rb_data_v[k] != '0) rb_nz[k] <= rb_nz[k] + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // One complete load on instance k; stall_len>0 withholds word 2 until word 1
  // has fully shifted, then for stall_len more cycles.
  task automatic run_load(input int k, input logic [31:0] w0, input logic [31:0] w1,
                          input int stall_len, input bit poke);
    int len, nw, e0, d0, a0, r0, guard, gap;
    logic [63:0] mask, exp_stream, got, snap;
    logic [31:0] words [2];
    logic rdy;
    len = (k == 0) ? 8 : 40;
    nw  = (len + W - 1) / W;
    words[0] = w0;
    words[1] = w1;
    mask = (64'd1 << len) - 64'd1;
    exp_stream = {w1, w0} & mask;
    snap = {24'd0, chain[k]} & mask;
    e0 = en_cnt[k]; d0 = done_cnt[k]; a0 = acc_cnt[k]; r0 = rb_cnt[k];
    $display("txn: load inst=%0d len=%0d w0=%h w1=%h stall=%0d poke=%0d",
             k, len, w0, w1, stall_len, poke);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    for (int w = 0; w < nw; w++) begin
      if (w == 1 && stall_len > 0) begin
        guard = 0;
        while ((en_cnt[k] - e0) < W && guard < 200) begin tick(); guard++; end
        repeat (stall_len) tick();
      end
      drv_data[k]  = words[w];
      drv_valid[k] = 1'b1;
      guard = 0;
      do begin
        rdy = rdy_v[k];
        tick();
        guard++;
      end while (!rdy && guard < 300);
      check("accept_handshake", rdy, 1);
      if (stall_len > 0 || w == nw - 1) drv_valid[k] = 1'b0;
    end
    if (poke) begin
      tick();
      check("poke_in_shift_busy", busy_v[k], 1);
      start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
    end
    guard = 0;
    while (done_cnt[k] == d0 && guard < 400) begin tick(); guard++; end
    repeat (3) tick();

    check("clk_en_count", en_cnt[k] - e0, len);
    check("done_count", done_cnt[k] - d0, 1);
    check("words_accepted", acc_cnt[k] - a0, nw);
    if (en_cnt[k] - e0 == len) begin
      got = '0;
      for (int i = 0; i < len; i++) got[i] = head_log[k][e0 + i];
      check("head_bits", got, exp_stream);
      check("done_after_last_en", done_cyc[k], en_cyc_log[k][e0 + len - 1] + 1);
      gap = en_cyc_log[k][e0 + len - 1] - en_cyc_log[k][e0] + 1 - len;
      if (stall_len == 0) check("no_bubble_gap", gap, 0);
      else check("stall_gap_in_range", (gap >= stall_len) && (gap <= stall_len + 3), 1);
    end
`ifdef CCFF_READBACK_EN
    check("rb_pulses", rb_cnt[k] - r0, nw);
    if (rb_cnt[k] - r0 == nw)
      for (int j = 0; j < nw; j++) check("rb_word", rb_log[k][r0 + j], (snap >> (W * j)) & 64'hFFFF_FFFF);
`else
    check("rb_absent", rb_cnt[k] - r0, 0);
`endif
  endtask

  initial begin
    int e0, e1, d0, a0, guard;
    drv_data[0] = '0;
    drv_data[1] = '0;

    // Reset values on both instances
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_s_ready", rdy_v[k], 0);
      check("rst_head", head_v[k], 0);
      check("rst_clk_en", en_v[k], 0);
      check("rst_busy", busy_v[k], 0);
      check("rst_done", done_v[k], 0);
      check("rst_rb_data", rb_data_v[k], 0);
      check("rst_rb_valid", rb_valid_v[k], 0);
    end
    prog_reset = 1'b0;
    repeat (2) tick();

    // Single short word, then reload of the same word (readback returns it)
    run_load(0, 32'h0000_00A5, 32'h0, 0, 0);
    run_load(0, 32'h0000_00A5, 32'h0, 0, 0);
    // Two words back to back, then with a starved stream before word 2
    run_load(1, $urandom, $urandom, 0, 0);
    run_load(1, $urandom, $urandom, 5, 0);

    // Reset in the middle of a load
    $display("txn: reset mid-load inst=0");
    e0 = en_cnt[0]; d0 = done_cnt[0];
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    drv_data[0]  = $urandom;
    drv_valid[0] = 1'b1;
    guard = 0;
    while ((en_cnt[0] - e0) < 3 && guard < 100) begin tick(); guard++; end
    drv_valid[0] = 1'b0;
    prog_reset = 1'b1;
    tick();
    prog_reset = 1'b0;
    check("abort_busy", busy_v[0], 0);
    e1 = en_cnt[0];
    repeat (10) tick();
    check("abort_no_more_shift", en_cnt[0], e1);
    check("abort_no_done", done_cnt[0] - d0, 0);
    run_load(0, $urandom, 32'h0, 0, 0);

    // start while shifting is ignored
    run_load(0, $urandom, 32'h0, 0, 1);

    // s_valid in IDLE is not accepted
    $display("txn: s_valid while idle inst=0");
    a0 = acc_cnt[0];
    drv_data[0]  = 32'hFFFF_FFFF;
    drv_valid[0] = 1'b1;
    repeat (4) begin
      check("idle_s_ready", rdy_v[0], 0);
      tick();
    end
    drv_valid[0] = 1'b0;
    check("idle_no_accept", acc_cnt[0] - a0, 0);
    run_load(0, $urandom, 32'h0, 0, 0);

    // Random loads on both instances
    for (int i = 0; i < 6; i++) begin
      int k, st;
      k  = i % 2;
      st = (k == 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      run_load(k, $urandom, $urandom, st, 0);
    end

    for (int k = 0; k < 2; k++) begin
      check("head_hold_when_gated", hold_bad[k], 0);
      check("ready_while_idle", idle_rdy_bad[k], 0);
`ifndef CCFF_READBACK_EN
      check("rb_data_tied_zero", rb_nz[k], 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_prog_ctrl.md
CCFF_PROG_CTRL -- requirements
Module: ccff_prog_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of configuration flip-flops in the target ccff chain (1..65535).
REQ-002 Parameter WORD_W, default 32: bitstream word width (8..64).
REQ-003 prog_clk  in  1  programming clock; the only clock.
REQ-004 prog_reset  in  1  reset; synchronous to prog_clk, active-high.
REQ-005 start  in  1  single-cycle request to begin loading; honoured only in IDLE.
REQ-006 s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  word accepted when s_valid && s_ready.
REQ-009 ccff_head  out  1  serial data into the chain head.
REQ-010 ccff_clk_en  out  1  enable for the clock gate feeding the chain's prog_clk; a shift occurs on each edge where it is high.
REQ-011 ccff_tail  in  1  serial data from the chain tail.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  single-cycle pulse on completion.
REQ-014 rb_data  out  WORD_W  readback word (CCFF_READBACK_EN only).
REQ-015 rb_valid  out  1  single-cycle readback word strobe (CCFF_READBACK_EN only).

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, SHIFT and DONE.
- IDLE->FETCH on start.
- FETCH->SHIFT when a word is in the shift register.
- SHIFT->FETCH when the word is exhausted, bits remain, and the buffer is empty.
- SHIFT->DONE after bit CHAIN_LEN-1.
- DONE->IDLE unconditionally.
REQ-017 The block SHALL hold a one-word prefetch buffer.
- s_ready = busy && buffer empty && (words accepted < ceil(CHAIN_LEN/WORD_W)).
- A full buffer SHALL load the shift register on the cycle the current word exhausts, giving back-to-back words no bubble.
REQ-018 In SHIFT, each cycle SHALL drive ccff_head = shift_reg[0] and ccff_clk_en = 1, then shift right by one and increment bit_cnt.
- ccff_clk_en SHALL be 0 in every other state.
REQ-019 The final word SHALL shift only CHAIN_LEN mod WORD_W bits (WORD_W if the remainder is 0); its upper bits are discarded.
REQ-020 bit_cnt SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and SHALL never wrap.
REQ-021 done SHALL pulse in the DONE cycle, exactly one cycle after the last ccff_clk_en-high cycle.
REQ-022 start while busy SHALL be ignored.
- s_valid while not busy SHALL NOT be accepted.
REQ-023 A starved stream (FETCH with no word) SHALL hold ccff_clk_en low indefinitely, with no timeout.
REQ-024 ccff_head SHALL hold its last driven value when ccff_clk_en is low.

Reset
REQ-025 While prog_reset is high at a prog_clk edge, the block SHALL go to IDLE and clear the buffer, bit_cnt and word counter.
- Outputs SHALL be s_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0, rb_data=0, rb_valid=0.
REQ-026 Reset mid-load SHALL abort without a done pulse; the chain contents are then undefined.

Configuration
REQ-027 With macro CCFF_READBACK_EN defined, ccff_tail SHALL be sampled in every ccff_clk_en-high cycle (pre-edge value) into rb_data.
- Bits fill LSB-first.
- rb_valid SHALL pulse the cycle after WORD_W bits are collected, or after the final bit, with the unfilled upper bits zero.
- rb_valid has no backpressure.
REQ-028 Without CCFF_READBACK_EN, rb_data and rb_valid SHALL be tied to 0, ccff_tail SHALL be unused, and no readback flops SHALL exist.

Structure
REQ-029 Package ccff_prog_pkg SHALL hold the FSM state enum and a function computing the word count and last-word bit count from CHAIN_LEN/WORD_W.
REQ-030 Sub-module ccff_word_buf SHALL implement the one-word prefetch buffer with a valid/ready interface; all other logic is flat.

Verification
REQ-031 CHAIN_LEN=8, WORD_W=32, start, word 0x000000A5 -> ccff_head 1,0,1,0,0,1,0,1 over 8 consecutive clk_en cycles, done one cycle later, one word accepted.
REQ-032 CHAIN_LEN=40, WORD_W=32, two words with s_valid held high -> 40 contiguous clk_en cycles with no bubble; only bits [7:0] of word 2 shifted.
REQ-033 Same as REQ-032 with s_valid deasserted for 5 cycles before word 2 -> clk_en low for exactly those stall cycles; total clk_en-high count 40.
REQ-034 Reset asserted after 3 shifted bits, then released -> busy=0, no done pulse; a new start reloads from bit 0.
REQ-035 CCFF_READBACK_EN, tail model = 8-bit shift chain preloaded 0x3C, load 0xA5 -> rb_data=0x0000003C with one rb_valid pulse; a second load returns 0x000000A5.
REQ-036 start pulsed during SHIFT, and s_valid presented in IDLE -> both ignored; s_ready stays 0 in IDLE.
